// File: rtl/scc_pkg.sv
// Shared definitions for the single-cycle computer front end.
//   - loader FSM state encoding
//   - default instruction word returned for empty or blocked fetches
package scc_pkg;

  localparam logic [1:0] ST_CLEAR = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0000;

endpackage : scc_pkg

// File: rtl/imem_array.sv
// DEPTH x 32 instruction word array.
// Ports:
//   clk          - write clock
//   we/waddr/wdata - synchronous write port
//   raddr/rdata  - asynchronous read port
module imem_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // No reset: the loader sweeps every word with NOP before the core runs.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule : imem_array

// File: rtl/instr_mem_loader.sv
// Instruction memory with boot-load front end for the single-cycle core.
// Clears the array, accepts a program over a valid/ready stream while holding
// the core in reset, then serves zero-latency instruction fetches.
// Ports:
//   clk, reset                    - clock, synchronous active-high reset
//   load_valid/data/last, load_ready - program load stream
//   reload                        - restart clear/load from RUN
//   in_mem_addr, in_mem_en, in_mem - fetch port to the core (in_mem is combinational)
//   cpu_reset                     - core reset, high unless running
//   loaded_words, load_overflow, fetch_fault - load count and sticky status flags
module instr_mem_loader
  import scc_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned AW       = 8,
  parameter logic [31:0] NOP_WORD = NOP_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          load_ready,
  input  logic          reload,
  input  logic [31:0]   in_mem_addr,
  input  logic          in_mem_en,
  output logic [31:0]   in_mem,
  output logic          cpu_reset,
  output logic [AW:0]   loaded_words,
  output logic          load_overflow,
  output logic          fetch_fault
);

  logic [1:0]    state, state_nxt;
  logic [AW-1:0] clr_ptr, clr_ptr_nxt;
  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic [AW:0]   loaded_words_nxt;
  logic          load_overflow_nxt, fetch_fault_nxt;
  logic          load_ready_nxt, cpu_reset_nxt;

  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wdata;
  logic [31:0]   rd_data;

  logic          accept, wr_at_end, addr_ok, fetch_hit, bad_fetch;

  // Fetch qualification: aligned and inside the array, only while running.
  assign addr_ok   = (in_mem_addr[1:0] == 2'b00) && (in_mem_addr[31:AW+2] == '0);
  assign fetch_hit = (state == ST_RUN) && in_mem_en && addr_ok;
  assign bad_fetch = (state == ST_RUN) && in_mem_en && !addr_ok;
  assign in_mem    = fetch_hit ? rd_data : NOP_WORD;

  assign accept    = load_valid && load_ready;
  assign wr_at_end = (wr_ptr == AW'(DEPTH - 1));

  // Next-state, pointer, flag and write-port logic.
  always_comb begin
    state_nxt         = state;
    clr_ptr_nxt       = clr_ptr;
    wr_ptr_nxt        = wr_ptr;
    loaded_words_nxt  = loaded_words;
    load_overflow_nxt = load_overflow;
    fetch_fault_nxt   = fetch_fault;
    we                = 1'b0;
    waddr             = clr_ptr;
    wdata             = NOP_WORD;

    case (state)
      ST_CLEAR: begin
        we          = 1'b1;
        clr_ptr_nxt = clr_ptr + AW'(1);
        if (clr_ptr == AW'(DEPTH - 1)) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (accept) begin
          we               = 1'b1;
          waddr            = wr_ptr;
          wdata            = load_data;
          loaded_words_nxt = loaded_words + (AW+1)'(1);
          // Pointer parks on the last index; a full array leaves LOAD anyway.
          if (!wr_at_end) wr_ptr_nxt = wr_ptr + AW'(1);
          if (load_last) begin
            state_nxt = ST_RUN;
          end else if (wr_at_end) begin
            load_overflow_nxt = 1'b1;
            state_nxt         = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bad_fetch) fetch_fault_nxt = 1'b1;
        if (reload) begin
          state_nxt         = ST_CLEAR;
          clr_ptr_nxt       = '0;
          wr_ptr_nxt        = '0;
          loaded_words_nxt  = '0;
          load_overflow_nxt = 1'b0;
          fetch_fault_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt   = ST_CLEAR;
        clr_ptr_nxt = '0;
      end
    endcase

    load_ready_nxt = (state_nxt == ST_LOAD);
    cpu_reset_nxt  = (state_nxt != ST_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_CLEAR;
      clr_ptr       <= '0;
      wr_ptr        <= '0;
      loaded_words  <= '0;
      load_overflow <= 1'b0;
      fetch_fault   <= 1'b0;
      load_ready    <= 1'b0;
      cpu_reset     <= 1'b1;
    end else begin
      state         <= state_nxt;
      clr_ptr       <= clr_ptr_nxt;
      wr_ptr        <= wr_ptr_nxt;
      loaded_words  <= loaded_words_nxt;
      load_overflow <= load_overflow_nxt;
      fetch_fault   <= fetch_fault_nxt;
      load_ready    <= load_ready_nxt;
      cpu_reset     <= cpu_reset_nxt;
    end
  end

  imem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_imem_array (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (in_mem_addr[AW+1:2]),
    .rdata (rd_data)
  );

endmodule : instr_mem_loader

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: clear timing, loads, fetch gating,
// faults, overflow, reload and mid-load reset.
module tb_instr_mem_loader;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned AW    = 8;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          load_valid;
  logic [31:0]   load_data;
  logic          load_last;
  logic          load_ready;
  logic          reload;
  logic [31:0]   in_mem_addr;
  logic          in_mem_en;
  logic [31:0]   in_mem;
  logic          cpu_reset;
  logic [AW:0]   loaded_words;
  logic          load_overflow;
  logic          fetch_fault;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instr_mem_loader #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NOP_WORD (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .load_valid    (load_valid),
    .load_data     (load_data),
    .load_last     (load_last),
    .load_ready    (load_ready),
    .reload        (reload),
    .in_mem_addr   (in_mem_addr),
    .in_mem_en     (in_mem_en),
    .in_mem        (in_mem),
    .cpu_reset     (cpu_reset),
    .loaded_words  (loaded_words),
    .load_overflow (load_overflow),
    .fetch_fault   (fetch_fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until load_ready rises; the clear sweep should take DEPTH.
  task automatic wait_clear(input string tag);
    int cycles = 0;
    do begin
      step();
      cycles++;
    end while (!load_ready && cycles < DEPTH + 20);
    check(tag, 32'(cycles), 32'(DEPTH));
  endtask

  task automatic send(input logic [31:0] data, input logic last);
    load_valid = 1'b1;
    load_data  = data;
    load_last  = last;
    step();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    in_mem_addr = addr;
    in_mem_en   = 1'b1;
    #1;
    check(tag, in_mem, exp);
  endtask

  task automatic do_reload();
    reload = 1'b1;
    step();
    reload = 1'b0;
  endtask

  initial begin
    int cycles;
    logic saw_bad;

    reset       = 1'b1;
    load_valid  = 1'b0;
    load_data   = '0;
    load_last   = 1'b0;
    reload      = 1'b0;
    in_mem_addr = '0;
    in_mem_en   = 1'b0;

    // Reset values.
    step();
    step();
    check("rst_load_ready", 32'(load_ready), 32'd0);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_loaded_words", 32'(loaded_words), 32'd0);
    check("rst_overflow", 32'(load_overflow), 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_in_mem", in_mem, NOP);

    // Clear sweep with a fetch of 0x0 held active: blocked and no fault.
    reset       = 1'b0;
    in_mem_addr = 32'h0;
    in_mem_en   = 1'b1;
    cycles      = 0;
    saw_bad     = 1'b0;
    do begin
      step();
      cycles++;
      if (!load_ready && (!cpu_reset || in_mem !== NOP || fetch_fault)) saw_bad = 1'b1;
    end while (!load_ready && cycles < DEPTH + 20);
    check("clear_len", 32'(cycles), 32'(DEPTH));
    check("clear_quiet", 32'(saw_bad), 32'd0);
    check("load_cpu_reset", 32'(cpu_reset), 32'd1);
    in_mem_en = 1'b0;

    // Three-word program with an idle cycle between words 1 and 2.
    send(32'h1111_1111, 1'b0);
    step();
    send(32'h2222_2222, 1'b0);
    check("load2_cpu_reset", 32'(cpu_reset), 32'd1);
    send(32'h3333_3333, 1'b1);
    check("load3_words", 32'(loaded_words), 32'd3);
    check("load3_cpu_reset", 32'(cpu_reset), 32'd0);
    check("load3_ready", 32'(load_ready), 32'd0);
    fetch("fetch_0", 32'h0, 32'h1111_1111);
    fetch("fetch_4", 32'h4, 32'h2222_2222);
    fetch("fetch_8", 32'h8, 32'h3333_3333);
    fetch("fetch_c", 32'hC, NOP);
    step();
    check("good_fetch_nofault", 32'(fetch_fault), 32'd0);

    // Reload: core back in reset next cycle, counters cleared, old words gone.
    do_reload();
    check("reload_cpu_reset", 32'(cpu_reset), 32'd1);
    check("reload_words", 32'(loaded_words), 32'd0);
    check("reload_overflow", 32'(load_overflow), 32'd0);
    wait_clear("reload_clear_len");
    send(32'hDEAD_BEEF, 1'b1);
    check("beef_words", 32'(loaded_words), 32'd1);
    fetch("beef_0", 32'h0, 32'hDEAD_BEEF);
    fetch("beef_old4", 32'h4, NOP);

    // Misaligned / out-of-range fetches.
    do_reload();
    wait_clear("fault_clear_len");
    send(32'hAAAA_0001, 1'b0);
    send(32'hAAAA_0002, 1'b1);
    in_mem_en   = 1'b0;
    in_mem_addr = 32'h6;
    #1;
    check("dis_in_mem", in_mem, NOP);
    step();
    in_mem_addr = 32'h400;
    step();
    check("dis_nofault", 32'(fetch_fault), 32'd0);
    fetch("mis_in_mem", 32'h6, NOP);
    step();
    check("mis_fault", 32'(fetch_fault), 32'd1);
    fetch("oor_in_mem", 32'h400, NOP);
    fetch("ok_after_fault", 32'h4, 32'hAAAA_0002);
    step();
    check("fault_sticky", 32'(fetch_fault), 32'd1);
    in_mem_en = 1'b0;
    do_reload();
    check("reload_clr_fault", 32'(fetch_fault), 32'd0);

    // Overflow: DEPTH words without last.
    wait_clear("ovf_clear_len");
    for (int i = 0; i < DEPTH; i++) send(32'hA000_0000 + 32'(i), 1'b0);
    check("ovf_flag", 32'(load_overflow), 32'd1);
    check("ovf_words", 32'(loaded_words), 32'(DEPTH));
    check("ovf_cpu_reset", 32'(cpu_reset), 32'd0);
    check("ovf_ready", 32'(load_ready), 32'd0);
    send(32'hFFFF_FFFF, 1'b1);
    check("ovf_words_after", 32'(loaded_words), 32'(DEPTH));
    fetch("ovf_first", 32'h0, 32'hA000_0000);
    fetch("ovf_last", 32'h3FC, 32'hA000_00FF);
    in_mem_en = 1'b0;

    // Reset in the middle of a load.
    do_reload();
    wait_clear("mid_clear_len");
    send(32'h5555_0000, 1'b0);
    send(32'h5555_0001, 1'b0);
    check("mid_words", 32'(loaded_words), 32'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mid_rst_words", 32'(loaded_words), 32'd0);
    check("mid_rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("mid_rst_ready", 32'(load_ready), 32'd0);
    wait_clear("mid_rst_clear_len");
    send(32'h7777_7777, 1'b1);
    fetch("mid_new_0", 32'h0, 32'h7777_7777);
    fetch("mid_old_4", 32'h4, NOP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop in case the sequence above is ever stuck.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule : tb_instr_mem_loader

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Instruction memory for the single-cycle computer, with a boot-load front end.
- Clears its word array, then accepts a program over a valid/ready stream while holding the core in reset.
- Releases the core, then serves same-cycle instruction fetches on in_mem_addr/in_mem_en -> in_mem.
- Sits directly upstream of SCC: drives SCC's in_mem input and its reset.

Parameters:
- DEPTH, 256: number of 32-bit instruction words; power of two, >= 4.
- AW, 8: word-index width, equal to log2(DEPTH).
- NOP_WORD, 32'h0000_0000: word returned for cleared, unloaded, out-of-range or blocked fetches.

Ports:
- clk  in  1: system clock, all state updates on the rising edge.
- reset  in  1: synchronous, active-high reset.
- load_valid  in  1: a load word is offered.
- load_data  in  32: the offered instruction word.
- load_last  in  1: qualifies the final word of the program.
- load_ready  out  1: the loader can accept a word this cycle.
- reload  in  1: one-cycle request in RUN to restart CLEAR/LOAD.
- in_mem_addr  in  32: byte fetch address from SCC.
- in_mem_en  in  1: fetch enable from SCC.
- in_mem  out  32: fetched instruction to SCC.
- cpu_reset  out  1: reset to SCC; high unless in RUN.
- loaded_words  out  AW+1: count of words written in the current load.
- load_overflow  out  1: sticky; program reached DEPTH words without load_last.
- fetch_fault  out  1: sticky; misaligned or out-of-range fetch seen while in RUN.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset). It overrides everything, including a load in progress.
- State after reset: state=CLEAR, clr_ptr=0, wr_ptr=0. Reset values of outputs: load_ready=0, cpu_reset=1, loaded_words=0, load_overflow=0, fetch_fault=0, in_mem=NOP_WORD.
- CLEAR:
  - Each cycle writes NOP_WORD to mem[clr_ptr] and increments clr_ptr.
  - After writing index DEPTH-1, goes to LOAD next cycle. CLEAR lasts exactly DEPTH cycles.
  - load_ready=0 throughout.
- LOAD:
  - load_ready=1.
  - A word is accepted when load_valid && load_ready at a rising edge. It writes mem[wr_ptr]=load_data; wr_ptr and loaded_words increment.
  - Accepted with load_last=1: go to RUN next cycle.
  - Accepted at wr_ptr==DEPTH-1 with load_last=0: the word is stored, load_overflow is set, and the state goes to RUN (overflow is treated as last).
  - load_valid with load_ready=0 is ignored, never stored.
  - load_last without load_valid has no effect.
- RUN:
  - cpu_reset=0 starting in the first RUN cycle. Latency from the accepted last word to cpu_reset low is 1 cycle.
  - load_ready=0.
  - reload=1 goes to CLEAR next cycle and clears wr_ptr, loaded_words, load_overflow and fetch_fault. cpu_reset returns high in that same next cycle.
  - reload in CLEAR or LOAD is ignored.
- Fetch path (combinational, zero latency, so a single-cycle core can fetch and execute in one cycle):
  - Word index = in_mem_addr[AW+1:2].
  - in_mem = mem[index] only when state==RUN && in_mem_en && in_mem_addr[1:0]==0 && in_mem_addr[31:AW+2]==0. Otherwise in_mem = NOP_WORD.
  - fetch_fault sets at the edge when state==RUN && in_mem_en && (misaligned || out-of-range). It is cleared only by reset or reload.
  - Fetches outside RUN never fault.
- Simultaneous events:
  - A load write and a fetch cannot collide, because fetches are blocked outside RUN.
  - reset together with reload: reset wins; result is identical.
- Width rules: loaded_words saturates naturally at DEPTH (AW+1 bits). wr_ptr is AW bits and never wraps, because overflow leaves LOAD.
- Memory: one write port (CLEAR and LOAD are mutually exclusive) and one asynchronous read port. Intended as distributed RAM or registers.

Decomposition:
- Shared package (scc_pkg): state encoding CLEAR=2'd0, LOAD=2'd1, RUN=2'd2, and the NOP_WORD default constant.
- One natural sub-module, imem_array: DEPTH x 32 array with a synchronous write port and an asynchronous read port.
- The loader FSM, pointers, flags and fetch gating stay in instr_mem_loader.

Test Plan:
- Reset, then hold load_valid=0: cpu_reset=1 and load_ready=0 for DEPTH cycles; load_ready=1 in cycle DEPTH. A fetch of addr 0x0 during this time returns NOP_WORD with no fault.
- Load 3 words 0x11111111, 0x22222222, 0x33333333 (last on the third) with one idle cycle between words 1 and 2: loaded_words=3, cpu_reset=0 the cycle after the third word. Fetches at 0x0/0x4/0x8 return those words; 0xC returns NOP_WORD.
- After a 2-word load, fetch 0x6 and 0x400 (DEPTH=256) with in_mem_en=1: in_mem=NOP_WORD and fetch_fault=1 and stays set. The same addresses with in_mem_en=0 raise no fault.
- Stream DEPTH words with no load_last: load_overflow=1, state RUN, loaded_words=256. A 257th load_valid sees load_ready=0 and memory is unchanged.
- In RUN pulse reload: cpu_reset=1 the next cycle, flags and loaded_words=0. After CLEAR, a fetch of the old address returns NOP_WORD. A new 1-word load of 0xDEADBEEF is readable at 0x0.
- Assert reset mid-LOAD after 2 words: next cycle state=CLEAR, loaded_words=0, cpu_reset=1. The words are cleared before LOAD re-opens.
